instr_fetch: RTL and testbench



---
 rtl/ifetch_pkg.sv | 25 ++
 rtl/ifetch_queue.sv | 74 +++++++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction fetch unit.
//   fetch_entry_t : one prefetch queue entry {pc, instr}
//   fetch_state_e : fetch FSM state (RUN / HALT)
//   INSTR_BYTES   : bytes per instruction word (pc increment)
//   fits_in_mem   : true when a whole instruction word at addr lies inside memory
package ifetch_pkg;

   localparam logic [63:0] INSTR_BYTES = 64'd4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // 65-bit sum so an address near 2^64 cannot wrap back into range.
   function automatic logic fits_in_mem(input logic [63:0] addr, input logic [63:0] mem_size);
      return ({1'b0, addr} + {1'b0, INSTR_BYTES - 64'd1}) < {1'b0, mem_size};
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: DEPTH-entry circular FIFO of fetch_entry_t used as the
// prefetch queue.
//   clk, rst_n : clock, async active-low reset
//   push       : write entry_in at the tail (ignored when full unless popping)
//   pop        : drop the head (ignored when empty)
//   flush      : clear the queue; wins over push
//   entry_in   : entry to write
//   full/empty : occupancy flags
//   head       : entry at the head (stale when empty)
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t entry_in,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t      mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_pop;
   logic              do_push;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // When full, a same-cycle pop frees the slot being written.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= entry_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit. Drives the fetch pc to a combinational
// instruction ROM, queues {pc, instr} pairs and hands them to decode through a
// valid/ready handshake. Branch redirects flush the queue and refetch.
//   clk, rst_n         : clock, async active-low reset
//   imem_addr          : ROM byte address (the fetch pc register)
//   imem_instr         : ROM read data for imem_addr
//   out_valid/ready    : decode handshake
//   out_instr, out_pc  : queue head (zero when the queue is empty)
//   redirect_valid/pc  : branch redirect request and target
//   fault              : fetch halted on an out-of-range or misaligned address
//   stall_cycles       : only with IFETCH_STATS_EN defined; counts cycles where
//                        decode was ready but nothing was valid (saturating)
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | fetching: push {pc, instr} whenever the queue has room
// HALT  | fetch stopped on a bad pc; queue drains, pc holds, fault=1
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] MEM_SIZE = 64'd1024,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        fault
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   fetch_state_e state;
   fetch_state_e state_next;
   logic [63:0]  pc;
   logic [63:0]  pc_next;

   logic         push;
   logic         pop;
   logic         flush;
   logic         q_full;
   logic         q_empty;
   fetch_entry_t head;
   fetch_entry_t new_entry;

   logic         pc_in_range;
   logic         target_ok;
   logic         can_accept;

   assign pc_in_range = fits_in_mem(pc, MEM_SIZE);
   assign target_ok   = (redirect_pc[1:0] == 2'b00) && fits_in_mem(redirect_pc, MEM_SIZE);
   assign pop         = out_valid && out_ready;
   assign can_accept  = !q_full || pop;
   assign new_entry   = '{pc: pc, instr: imem_instr};

   assign imem_addr = pc;
   assign out_valid = !q_empty;
   assign out_instr = q_empty ? '0 : head.instr;
   assign out_pc    = q_empty ? '0 : head.pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (redirect_valid) begin
         if (target_ok) begin
            state_next = RUN;
            pc_next    = redirect_pc;
         end else begin
            state_next = HALT;
         end
      end else if (state == RUN) begin
         if (!pc_in_range) begin
            state_next = HALT;
         end else if (can_accept) begin
            pc_next = pc + INSTR_BYTES;
         end
      end
   end

   always_comb begin
      flush = redirect_valid;
      push  = 1'b0;
      fault = (state == HALT);
      if (!redirect_valid && (state == RUN) && pc_in_range && can_accept) begin
         push = 1'b1;
      end
   end

   ifetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .entry_in (new_entry),
      .full     (q_full),
      .empty    (q_empty),
      .head     (head)
   );

`ifdef IFETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (out_ready && !out_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   import ifetch_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] MEM_SIZE = 64'd1024;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        fault;
`ifdef IFETCH_STATS_EN
   logic [31:0] stall_cycles;
`endif

   logic [31:0] rom [256];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   fetch_entry_t mq [$];
   logic [63:0]  m_pc;
   bit           m_halt;
   int unsigned  m_stall;

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr < MEM_SIZE) ? rom[imem_addr[9:2]] : 32'hBAD0_BAD0;

   instr_fetch #(
      .DEPTH    (DEPTH),
      .MEM_SIZE (MEM_SIZE),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fault          (fault)
`ifdef IFETCH_STATS_EN
      ,
      .stall_cycles   (stall_cycles)
`endif
   );

   task automatic model_reset();
      mq.delete();
      m_pc    = RESET_PC;
      m_halt  = 1'b0;
      m_stall = 0;
   endtask

   // Drive one cycle of inputs, clock once, advance the model, settle.
   task automatic tick(input logic rdy, input logic rv, input logic [63:0] rpc);
      fetch_entry_t e;
      bit           popped;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      popped = rdy && (mq.size() > 0);
      if (rdy && mq.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (rv) begin
         mq.delete();
         if (rpc[1:0] == 2'b00 && rpc < MEM_SIZE - 3) begin
            m_pc   = rpc;
            m_halt = 1'b0;
         end else begin
            m_halt = 1'b1;
         end
      end else begin
         if (popped) void'(mq.pop_front());
         if (!m_halt) begin
            if (m_pc >= MEM_SIZE - 3) begin
               m_halt = 1'b1;
            end else if (mq.size() < DEPTH) begin
               e.pc    = m_pc;
               e.instr = rom[m_pc[9:2]];
               mq.push_back(e);
               m_pc = m_pc + 64'd4;
            end
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got valid=%b pc=%h instr=%h fault=%b exp 0/0/0/0",
                  out_valid, out_pc, out_instr, fault);
      end
      n_checks++;
      if (imem_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC);
      end
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL release_valid got=%b exp=0", out_valid);
      end
      tick(1'b1, 1'b0, '0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== rom[0]) begin
         n_fail++;
         $display("FAIL first_fetch got valid=%b pc=%h instr=%h exp 1/0/%h",
                  out_valid, out_pc, out_instr, rom[0]);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== rom[i]) begin
            n_fail++;
            $display("FAIL stream i=%0d got valid=%b pc=%h instr=%h exp 1/%h/%h",
                     i, out_valid, out_pc, out_instr, 64'(4 * i), rom[i]);
         end
         tick(1'b1, 1'b0, '0);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);
      n_checks++;
      if (imem_addr !== 64'd16 || mq.size() != 4) begin
         n_fail++;
         $display("FAIL bp_fill got addr=%h exp 16 (model depth %0d)", imem_addr, mq.size());
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== rom[i]) begin
            n_fail++;
            $display("FAIL bp_drain i=%0d got valid=%b pc=%h exp 1/%h", i, out_valid, out_pc, 64'(4 * i));
         end
         tick(1'b1, 1'b0, '0);
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, '0);
      tick(1'b1, 1'b1, 64'h40);
      n_checks++;
      if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
         n_fail++;
         $display("FAIL redir_bubble got valid=%b addr=%h exp 0/40", out_valid, imem_addr);
      end
      tick(1'b1, 1'b0, '0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== rom[16]) begin
         n_fail++;
         $display("FAIL redir_target got valid=%b pc=%h instr=%h exp 1/40/%h", out_valid, out_pc, out_instr, rom[16]);
      end
      tick(1'b1, 1'b0, '0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h44) begin
         n_fail++;
         $display("FAIL redir_next got valid=%b pc=%h exp 1/44", out_valid, out_pc);
      end
   endtask

   task automatic test_bad_redirect();
      logic [63:0] held;
      apply_reset();
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, '0);
      held = m_pc;
      tick(1'b0, 1'b1, 64'h42);
      n_checks++;
      if (fault !== 1'b1 || imem_addr !== held || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misaligned got fault=%b addr=%h valid=%b exp 1/%h/0", fault, imem_addr, out_valid, held);
      end
      for (int i = 0; i < 6; i++) tick(1'($urandom_range(0, 1)), 1'b0, '0);
      n_checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== held) begin
         n_fail++;
         $display("FAIL halted_hold got fault=%b valid=%b addr=%h exp 1/0/%h", fault, out_valid, imem_addr, held);
      end
      tick(1'b1, 1'b1, 64'h8);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
      tick(1'b1, 1'b1, 64'h400);
      n_checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL oob_target got fault=%b valid=%b exp 1/0", fault, out_valid);
      end
      tick(1'b1, 1'b1, 64'h8);
      n_checks++;
      if (fault !== 1'b0 || imem_addr !== 64'h8) begin
         n_fail++;
         $display("FAIL recover got fault=%b addr=%h exp 0/8", fault, imem_addr);
      end
      tick(1'b1, 1'b0, '0);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 64'h8 || out_instr !== rom[2]) begin
         n_fail++;
         $display("FAIL recover_head got valid=%b pc=%h exp 1/8", out_valid, out_pc);
      end
   endtask

   task automatic test_end_of_mem();
      bit saw_last = 1'b0;
      tick(1'b1, 1'b1, 64'h3F0);
      for (int i = 0; i < 12; i++) begin
         if (out_valid === 1'b1 && out_pc === 64'h3FC && out_instr === rom[255]) saw_last = 1'b1;
         tick(1'b1, 1'b0, '0);
      end
      n_checks++;
      if (!saw_last) begin
         n_fail++;
         $display("FAIL end_last_word got delivered=0 exp 1");
      end
      n_checks++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h400) begin
         n_fail++;
         $display("FAIL end_halt got fault=%b valid=%b addr=%h exp 1/0/400", fault, out_valid, imem_addr);
      end
   endtask

   task automatic test_random();
      logic [63:0] t;
      logic        rv;
      for (int c = 0; c < 500; c++) begin
         rv = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 4))
            0:       t = 64'($urandom_range(0, 255)) << 2;
            1:       t = (64'($urandom_range(0, 255)) << 2) | 64'd2;
            2:       t = 64'h400 + (64'($urandom_range(0, 63)) << 2);
            3:       t = 64'h3F0;
            default: t = {32'hFFFF_FFFF, $urandom} & ~64'd3;
         endcase
         tick(1'($urandom_range(0, 3) != 0), rv, t);
         n_checks++;
         if (out_valid !== (mq.size() > 0)) begin
            n_fail++;
            $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, mq.size() > 0);
         end
         if (mq.size() > 0) begin
            n_checks++;
            if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
               n_fail++;
               $display("FAIL rand_head c=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                        c, out_pc, out_instr, mq[0].pc, mq[0].instr);
            end
         end
         n_checks++;
         if (imem_addr !== m_pc || fault !== m_halt) begin
            n_fail++;
            $display("FAIL rand_pc c=%0d got addr=%h fault=%b exp addr=%h fault=%b",
                     c, imem_addr, fault, m_pc, m_halt);
         end
`ifdef IFETCH_STATS_EN
         n_checks++;
         if (stall_cycles !== m_stall) begin
            n_fail++;
            $display("FAIL rand_stall c=%0d got=%0d exp=%0d", c, stall_cycles, m_stall);
         end
`endif
      end
   endtask

   task automatic test_reset_midrun();
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 64'h42);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL midrun_reset got valid=%b fault=%b addr=%h exp 0/0/%h", out_valid, fault, imem_addr, RESET_PC);
      end
`ifdef IFETCH_STATS_EN
      n_checks++;
      if (stall_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL midrun_stall got=%0d exp=0", stall_cycles);
      end
`endif
      @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
   endtask

`ifdef IFETCH_STATS_EN
   task automatic test_stats();
      apply_reset();
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 64'h40);
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      n_checks++;
      if (stall_cycles !== 32'd2) begin
         n_fail++;
         $display("FAIL stats_bubble got=%0d exp=2", stall_cycles);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_bad_redirect();
      test_end_of_mem();
      test_random();
      test_reset_midrun();
`ifdef IFETCH_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
